// File: rtl/flash_boot_loader_pkg.sv
// Shared types and defaults for the boot loader.
// Optional feature: BOOT_CHECKSUM_EN adds a trailing checksum word and the CHECK state.
package flash_boot_loader_pkg;

  localparam int          WAIT_START_MAX = 4;
  localparam logic [15:0] DEF_FLASH_BASE = 16'h0000;
  localparam int          DEF_BOOT_WORDS = 256;
  localparam int          DEF_TIMEOUT    = 4095;
  localparam int          CNT_W          = 16;

  typedef enum logic [2:0] {
    ST_REQ,
    ST_WAIT_START,
    ST_WAIT_DONE,
    ST_STORE,
`ifdef BOOT_CHECKSUM_EN
    ST_CHECK,
`endif
    ST_DONE,
    ST_FAIL
  } state_e;

  // Flash byte address of boot word idx, wrapping at 64 KiB.
  function automatic logic [15:0] word_addr(input logic [15:0] base, input logic [15:0] idx);
    return base + {idx[14:0], 1'b0};
  endfunction

endpackage

// File: rtl/flash_boot_loader_if.sv
// Flash-controller request side and CPU RAM write port of the boot loader.
interface flash_boot_loader_if;
  logic [15:0] fl_adresse;
  logic        fl_cs;
  logic        fl_write;
  logic [15:0] fl_datain;
  logic [15:0] fl_dataout;
  logic        fl_busy;
  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;

  modport master (
    output fl_adresse, fl_cs, fl_write, fl_datain, ram_addr, ram_wdata, ram_we,
    input  fl_dataout, fl_busy
  );

  modport slave (
    input  fl_adresse, fl_cs, fl_write, fl_datain, ram_addr, ram_wdata, ram_we,
    output fl_dataout, fl_busy
  );
endinterface

// File: rtl/boot_timeout_cnt.sv
// Loadable down-counter; expired_o is high once the count has reached zero.
module boot_timeout_cnt
  import flash_boot_loader_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         cnt_q <= '0;
    else if (load_i)                 cnt_q <= load_val_i;
    else if (dec_i && cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/flash_boot_loader.sv
// Boot copy engine: reads BOOT_WORDS words from SPI flash into CPU RAM while
// holding the CPU in reset. Define BOOT_CHECKSUM_EN to verify a trailing
// 16-bit additive checksum word before releasing the CPU.
module flash_boot_loader
  import flash_boot_loader_pkg::*;
#(
  parameter int          BOOT_WORDS = DEF_BOOT_WORDS,
  parameter logic [15:0] FLASH_BASE = DEF_FLASH_BASE,
  parameter int          TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       reboot_i,
  flash_boot_loader_if.master        bus,
  output logic                       cpu_hold_o,
  output logic                       done_o,
  output logic                       err_o
);

  localparam logic [15:0]      LAST_IDX = 16'(BOOT_WORDS - 1);
  // Counter expires after the last allowed cycle, so load max-1.
  localparam logic [CNT_W-1:0] WS_LOAD  = CNT_W'(WAIT_START_MAX - 1);
  localparam logic [CNT_W-1:0] WD_LOAD  = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [15:0]       idx_q, idx_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              cnt_load, cnt_dec, cnt_exp;
  logic [CNT_W-1:0]  cnt_val;
`ifdef BOOT_CHECKSUM_EN
  logic [15:0]       sum_q, sum_d;
`endif

  boot_timeout_cnt #(.W(CNT_W)) u_tmo (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load),
    .load_val_i(cnt_val),
    .dec_i     (cnt_dec),
    .expired_o (cnt_exp)
  );

  // State register; reset lands in REQ so the copy starts on its own.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_REQ;
    else     state_q <= state_d;
  end

  // Word index, captured data and running sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      wdata_q <= '0;
`ifdef BOOT_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
`ifdef BOOT_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    cnt_load = 1'b0;
    cnt_val  = WS_LOAD;
    cnt_dec  = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    sum_d    = sum_q;
`endif
    case (state_q)
      ST_REQ: begin
        cnt_load = 1'b1;
        state_d  = ST_WAIT_START;
      end
`ifdef BOOT_CHECKSUM_EN
      // Checksum fetch: same handshake as a data word, idx already at BOOT_WORDS.
      ST_CHECK: begin
        cnt_load = 1'b1;
        state_d  = ST_WAIT_START;
      end
`endif
      ST_WAIT_START: begin
        if (bus.fl_busy) begin
          cnt_load = 1'b1;
          cnt_val  = WD_LOAD;
          state_d  = ST_WAIT_DONE;
        end else if (cnt_exp) begin
          state_d = ST_FAIL;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.fl_busy) begin
`ifdef BOOT_CHECKSUM_EN
          if (idx_q == 16'(BOOT_WORDS))
            state_d = (bus.fl_dataout == sum_q) ? ST_DONE : ST_FAIL;
          else
`endif
          begin
            wdata_d = bus.fl_dataout;
            state_d = ST_STORE;
          end
        end else if (cnt_exp) begin
          state_d = ST_FAIL;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_STORE: begin
        idx_d = idx_q + 16'd1;
`ifdef BOOT_CHECKSUM_EN
        sum_d   = sum_q + wdata_q;
        state_d = (idx_q == LAST_IDX) ? ST_CHECK : ST_REQ;
`else
        state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_REQ;
`endif
      end
      ST_DONE, ST_FAIL: begin
        if (reboot_i) begin
          idx_d   = '0;
`ifdef BOOT_CHECKSUM_EN
          sum_d   = '0;
`endif
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  // Strobe is kept low while reset is held even though the reset state is REQ.
`ifdef BOOT_CHECKSUM_EN
  assign bus.fl_cs = ((state_q == ST_REQ) || (state_q == ST_CHECK)) && !rst;
`else
  assign bus.fl_cs = (state_q == ST_REQ) && !rst;
`endif
  assign bus.fl_adresse = word_addr(FLASH_BASE, idx_q);
  assign bus.fl_write   = 1'b0;
  assign bus.fl_datain  = 16'h0000;
  assign bus.ram_addr   = idx_q;
  assign bus.ram_wdata  = wdata_q;
  assign bus.ram_we     = (state_q == ST_STORE);
  assign cpu_hold_o     = (state_q != ST_DONE);
  assign done_o         = (state_q == ST_DONE);
  assign err_o          = (state_q == ST_FAIL);

endmodule

// File: tb/tb_flash_boot_loader.sv
// Scoreboard bench: a flash model answers requests; expected flash addresses and
// RAM writes are queued per run and popped by a negedge monitor.
module tb_flash_boot_loader;

  localparam int          BW   = 4;
  localparam logic [15:0] BASE = 16'h2000;
  localparam int          TO   = 100;

  logic clk = 1'b0, rst = 1'b1, reboot = 1'b0;
  logic cpu_hold, done, err;

  flash_boot_loader_if bus();

  flash_boot_loader #(.BOOT_WORDS(BW), .FLASH_BASE(BASE), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .reboot_i(reboot), .bus(bus),
    .cpu_hold_o(cpu_hold), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_bad = 0, wr_cnt = 0;
  logic [15:0] mem [BW+1];
  int          lat_fix = 40;
  bit          no_busy = 1'b0;
  logic [15:0] req_q [$];
  logic [31:0] wr_q  [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Flash controller model: busy rises the cycle after CS, stays up lat cycles.
  initial begin
    int          cnt, k;
    logic        cs_s;
    logic [15:0] a_s, rdat;
    bus.fl_busy = 1'b0; bus.fl_dataout = 16'h0; cnt = 0; rdat = 16'h0;
    forever begin
      @(negedge clk); cs_s = bus.fl_cs; a_s = bus.fl_adresse;
      @(posedge clk); #1;
      if (rst) begin
        bus.fl_busy = 1'b0; cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin bus.fl_busy = 1'b0; bus.fl_dataout = rdat; end
        end
        if (cs_s && !no_busy) begin
          k    = int'((a_s - BASE) >> 1);
          rdat = (k <= BW) ? mem[k] : 16'hDEAD;
          bus.fl_busy = 1'b1;
          bus.fl_dataout = 16'($urandom);
          cnt = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 60));
        end
      end
    end
  end

  // Monitor: every request and every RAM write must match the next expectation.
  always @(negedge clk) begin
    logic [31:0] e;
    if (bus.fl_cs) begin
      chk("cs_while_busy", 32'(bus.fl_busy), 32'd0);
      if (req_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_req: got addr %0h expected none", bus.fl_adresse);
      end else chk("req_addr", 32'(bus.fl_adresse), 32'(req_q.pop_front()));
    end
    if (bus.ram_we) begin
      wr_cnt++;
      if (wr_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_we: got addr %0h expected none", bus.ram_addr);
      end else begin
        e = wr_q.pop_front();
        chk("ram_addr",  32'(bus.ram_addr),  32'(e[31:16]));
        chk("ram_wdata", 32'(bus.ram_wdata), 32'(e[15:0]));
      end
    end
  end

  task automatic fill_mem(input bit bad_sum);
    logic [15:0] s = 16'h0;
    for (int i = 0; i < BW; i++) begin mem[i] = 16'($urandom); s += mem[i]; end
    mem[BW] = s + 16'(bad_sum);
  endtask

  task automatic expect_copy();
    for (int i = 0; i < BW; i++) begin
      req_q.push_back(BASE + 16'(2 * i));
      wr_q.push_back({16'(i), mem[i]});
    end
`ifdef BOOT_CHECKSUM_EN
    req_q.push_back(BASE + 16'(2 * BW));
`endif
  endtask

  task automatic chk_reset_vals();
    chk("rst_fl_cs", 32'(bus.fl_cs), 0);
    chk("rst_fl_adresse", 32'(bus.fl_adresse), 32'(BASE));
    chk("rst_fl_write", 32'(bus.fl_write), 0);
    chk("rst_fl_datain", 32'(bus.fl_datain), 0);
    chk("rst_ram_we", 32'(bus.ram_we), 0);
    chk("rst_ram_addr", 32'(bus.ram_addr), 0);
    chk("rst_ram_wdata", 32'(bus.ram_wdata), 0);
    chk("rst_cpu_hold", 32'(cpu_hold), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
  endtask

  task automatic assert_rst();
    @(posedge clk); #3 rst = 1'b1;
    #1 chk_reset_vals();
    req_q.delete(); wr_q.delete();
  endtask

  task automatic release_rst();
    @(posedge clk); #2 rst = 1'b0;
  endtask

  task automatic pulse_reboot();
    @(posedge clk); #2 reboot = 1'b1;
    @(posedge clk); #2 reboot = 1'b0;
  endtask

  // Cycles from the release/reboot cycle until done or err; bounded.
  task automatic wait_flag(output int n);
    n = 0;
    while (n < 5000) begin
      @(posedge clk); #1; n++;
      if (done || err) break;
    end
    if (!(done || err)) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_timeout: got no done/err expected one within 5000 cycles");
    end
  endtask

  task automatic chk_end(input string tag, input bit exp_ok, input int exp_wr);
    chk({tag, "_done"}, 32'(done), 32'(exp_ok));
    chk({tag, "_err"}, 32'(err), 32'(!exp_ok));
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!exp_ok));
    chk({tag, "_writes"}, 32'(wr_cnt), 32'(exp_wr));
    chk({tag, "_req_left"}, 32'(req_q.size()), 0);
    chk({tag, "_wr_left"}, 32'(wr_q.size()), 0);
  endtask

  initial begin
    int n, bound;
    repeat (3) @(posedge clk);
    #1 chk_reset_vals();

    // Fixed pattern, 40-cycle reads: checks exact per-word latency.
    for (int i = 0; i < BW; i++) mem[i] = 16'hA000 + 16'(i);
    mem[BW] = 16'hA000 * 16'(BW) + 16'(BW * (BW - 1) / 2);
    expect_copy(); wr_cnt = 0;
    release_rst(); wait_flag(n);
`ifdef BOOT_CHECKSUM_EN
    chk("latency_fixed", 32'(n), 32'(BW * 43 + 42));
`else
    chk("latency_fixed", 32'(n), 32'(BW * 43));
`endif
    chk_end("fixed", 1'b1, BW);

    // Reboot from DONE with random content and latency.
    lat_fix = 0; fill_mem(1'b0); expect_copy(); wr_cnt = 0;
    pulse_reboot();
    chk("reboot_cpu_hold", 32'(cpu_hold), 1);
    chk("reboot_done", 32'(done), 0);
    wait_flag(n); chk_end("reboot", 1'b1, BW);

    // Random runs; a reboot pulse mid-copy must be ignored.
    for (int r = 0; r < 3; r++) begin
      assert_rst(); fill_mem(1'b0); expect_copy(); wr_cnt = 0;
      release_rst();
      repeat (15) @(posedge clk);
      pulse_reboot();
      wait_flag(n); chk_end("random", 1'b1, BW);
    end

    // Reset while word 2 is in flight, then a full copy from word 0.
    assert_rst(); fill_mem(1'b0); expect_copy(); wr_cnt = 0;
    release_rst();
    bound = 0;
    while (wr_cnt < 2 && bound < 1000) begin @(posedge clk); bound++; end
    chk("mid_writes_seen", 32'(wr_cnt), 2);
    repeat (3) @(posedge clk);
    assert_rst(); expect_copy(); wr_cnt = 0;
    release_rst(); wait_flag(n); chk_end("after_rst", 1'b1, BW);

    // Flash never goes busy: fail five cycles after the strobe.
    assert_rst(); no_busy = 1'b1; req_q.push_back(BASE); wr_cnt = 0;
    release_rst(); wait_flag(n);
    chk("nobusy_cycles", 32'(n), 5);
    chk_end("nobusy", 1'b0, 0);
    no_busy = 1'b0;

    // Busy stuck beyond TIMEOUT.
    assert_rst(); lat_fix = 300; req_q.push_back(BASE); wr_cnt = 0;
    release_rst(); wait_flag(n);
    chk("timeout_cycles", 32'(n), 32'(TO + 2));
    chk_end("timeout", 1'b0, 0);

    // Reboot out of FAIL once the stuck flash has recovered.
    bound = 0;
    while (bus.fl_busy && bound < 500) begin @(posedge clk); #1; bound++; end
    lat_fix = 0; fill_mem(1'b0); expect_copy(); wr_cnt = 0;
    pulse_reboot();
    chk("fail_reboot_err", 32'(err), 0);
    chk("fail_reboot_hold", 32'(cpu_hold), 1);
    wait_flag(n); chk_end("fail_reboot", 1'b1, BW);

`ifdef BOOT_CHECKSUM_EN
    // Wrong checksum: all words still written, then error.
    assert_rst(); fill_mem(1'b1); expect_copy(); wr_cnt = 0;
    release_rst(); wait_flag(n); chk_end("bad_sum", 1'b0, BW);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/flash_boot_loader.md
# flash_boot_loader

Boot-time copy engine that sits directly upstream of the SPI flash controller: after reset it issues a sequence of single-word read requests to `flash`, collects each returned 16-bit word and writes it into the CPU instruction/data RAM, holding the CPU in reset until the image is loaded. It owns the flash controller's request side (`adresse`, `CS`, `write`, `DataIN`) during boot and releases the CPU via `cpu_hold` when done.

## Interface
- `BOOT_WORDS`, 256: number of 16-bit words copied to RAM (1..32768).
- `FLASH_BASE`, 16'h0000: flash byte address of word 0. Must be even; `FLASH_BASE + 2*BOOT_WORDS` (+2 with checksum) ≤ 65536.
- `TIMEOUT`, 4095: max cycles `fl_busy` may stay high for one word before failing.
- `clk` in 1: system clock, same clock as `flash`.
- `rst` in 1: asynchronous, active-high reset.
- `reboot` in 1: single-cycle pulse; restarts the copy from DONE or FAIL, ignored otherwise.
- `fl_adresse` out 16: byte address to `flash.adresse`.
- `fl_cs` out 1: one-cycle request strobe to `flash.CS`.
- `fl_write` out 1: tied 0 (read only).
- `fl_datain` out 16: tied 0.
- `fl_dataout` in 16: `flash.DataOUT`.
- `fl_busy` in 1: `flash.busy`.
- `ram_addr` out 16: RAM word address.
- `ram_wdata` out 16: RAM write data.
- `ram_we` out 1: RAM write enable, one cycle per word.
- `cpu_hold` out 1: 1 keeps CPU in reset.
- `done` out 1: image loaded.
- `err` out 1: timeout or checksum failure.

## Operation
- Reset values: `fl_adresse`=FLASH_BASE, `fl_cs`=0, `ram_addr`=0, `ram_wdata`=0, `ram_we`=0, `cpu_hold`=1, `done`=0, `err`=0; word counter `idx`=0; FSM in REQ (copy starts automatically).
- States: REQ → WAIT_START → WAIT_DONE → STORE → (REQ | CHECK | DONE); FAIL; DONE.
- REQ: `fl_cs`=1 for exactly one cycle, `fl_adresse`=FLASH_BASE + 2*idx (mod 2^16, held stable until STORE). Next WAIT_START.
- WAIT_START: wait for `fl_busy`=1 → WAIT_DONE. If not seen within 4 cycles → FAIL.
- WAIT_DONE: count cycles; `fl_busy`=0 → capture `fl_dataout` into `ram_wdata`, go STORE. Count exceeds TIMEOUT → FAIL.
- STORE: `ram_we`=1, `ram_addr`=idx. idx+1; if idx was BOOT_WORDS-1 → DONE (or CHECK with checksum), else REQ.
- DONE: `done`=1, `cpu_hold`=0, outputs idle. FAIL: `err`=1, `cpu_hold`=1, `done`=0.
- `reboot` in DONE/FAIL: clear `done`, `err`, idx, sum; `cpu_hold`=1; go REQ next cycle.
- `rst` mid-copy: immediate return to reset values; partial RAM content is not cleared, copy restarts from word 0.

## Timing
- `fl_cs` never asserted while `fl_busy`=1; minimum one cycle of `fl_busy`=0 between requests (STORE cycle).
- `flash` raises `fl_busy` one cycle after sampling `fl_cs`; WAIT_START normally exits after 1 cycle.
- Per-word latency = flash read time + 3 cycles (REQ, WAIT_START, STORE).
- `ram_we` pulse and captured data are in the same cycle; RAM samples on following clk edge.
- `done` and `cpu_hold` deassert in the same cycle.

## Configuration
- `BOOT_CHECKSUM_EN` defined: one extra word read at FLASH_BASE + 2*BOOT_WORDS, not written to RAM (CHECK state reads it like REQ..WAIT_DONE, no `ram_we`). 16-bit running sum (mod 2^16) of the BOOT_WORDS stored words is compared; equal → DONE, else FAIL with `err`=1.
- Undefined: no sum register, no CHECK state; DONE directly after last STORE.

## Structure
- Shared package: FSM state enum, `WAIT_START_MAX`=4, default `FLASH_BASE`/`BOOT_WORDS`.
- Sub-module: `boot_timeout_cnt` (loadable down-counter with expiry flag), used by WAIT_START and WAIT_DONE.

## Test plan
- BOOT_WORDS=4, flash model returning 16'hA000+idx, busy 40 cycles → RAM words 0..3 = A000..A003, byte addresses 0,2,4,6, `done`=1, `cpu_hold`=0.
- Flash model never raises busy → `err`=1 five cycles after `fl_cs`, `cpu_hold`=1, no `ram_we`.
- Busy held high > TIMEOUT (TIMEOUT=100) → `err`=1 at cycle 101 of WAIT_DONE.
- `BOOT_CHECKSUM_EN`, words 1,2,3,4 + checksum 10 → `done`=1; checksum 11 → `err`=1, only 4 `ram_we` pulses in both.
- `rst` asserted during word 2 → all outputs at reset values immediately; after release copy restarts at address FLASH_BASE.
- `reboot` pulse in DONE → `cpu_hold`=1 next cycle, full copy repeats, `done` returns to 1.
